// File: rtl/stdp_pkg.sv
// Purpose : shared widths, types and FSM encoding for the STDP sweep scheduler.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: W_WIDTH/HIST_LEN, weight_t, hist_t, sched_state_t, sat_weight().
package stdp_pkg;

   localparam int W_WIDTH  = 20;
   localparam int HIST_LEN = 16;

   typedef logic signed [W_WIDTH-1:0] weight_t;
   typedef logic [HIST_LEN-1:0]       hist_t;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      W1,
      W2,
      DONE
   } sched_state_t;

   // Signed saturation of a weight into [lo, hi].
   function automatic weight_t sat_weight(input weight_t v, input weight_t lo, input weight_t hi);
      if (v < lo) begin
         return lo;
      end
      if (v > hi) begin
         return hi;
      end
      return v;
   endfunction

endpackage

// File: rtl/stdp_spike_history.sv
// Purpose : N_SYN pre-synaptic histories plus one post-synaptic history, with a read mux.
// Latency : a shift lands on the next edge; read ports are combinational.
// Backpr. : none; shifts every cycle shift is high.
// Ports   : clk/rst (sync, active-high); shift strobe; pre_spike/post_spike new bits;
//           sel picks the pre history driven on pre_word; post_word is the shared history.
module stdp_spike_history
   import stdp_pkg::*;
#(
   parameter int N_SYN = 8,
   parameter int IDX_W = $clog2(N_SYN)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                shift,
   input  logic [N_SYN-1:0]    pre_spike,
   input  logic                post_spike,
   input  logic [IDX_W-1:0]    sel,
   output logic [HIST_LEN-1:0] pre_word,
   output logic [HIST_LEN-1:0] post_word
);

   hist_t pre_hist [N_SYN];
   hist_t post_hist;

   // Bit HIST_LEN-1 is the newest step; older steps move toward bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_SYN; i++) begin
            pre_hist[i] <= '0;
         end
         post_hist <= '0;
      end else if (shift) begin
         for (int i = 0; i < N_SYN; i++) begin
            pre_hist[i] <= {pre_spike[i], pre_hist[i][HIST_LEN-1:1]};
         end
         post_hist <= {post_spike, post_hist[HIST_LEN-1:1]};
      end
   end

   assign pre_word  = pre_hist[sel];
   assign post_word = post_hist;

endmodule

// File: rtl/stdp_sweep_scheduler.sv
// Purpose : per time-step STDP sweep: shift histories, then read/encode/write every synapse weight.
// Latency : tick -> first read 1 cycle; 3 cycles per synapse; done at 3*N_SYN+1, idle at 3*N_SYN+2.
// Backpr. : none; ticks arriving while busy (including the done cycle) are dropped and flag overrun.
// Ports   : clk, rst (sync, active-high); tick/pre_spike/post_spike step inputs;
//           mem_re/mem_we/mem_addr/mem_rdata/mem_wdata weight RAM (read data one cycle after mem_re);
//           enc_pre/enc_post/enc_cur_w to the shared encoder, enc_new_w back from it;
//           busy, done (1-cycle), overrun (1-cycle).
// Build   : define STDP_CLAMP_EN to saturate written weights to [W_MIN, W_MAX]; otherwise raw wrap.
module stdp_sweep_scheduler
   import stdp_pkg::*;
#(
   parameter int        N_SYN = 8,
   parameter int signed W_MIN = 0,
   parameter int signed W_MAX = 1023
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic [N_SYN-1:0]           pre_spike,
   input  logic                       post_spike,
   output logic                       mem_re,
   output logic                       mem_we,
   output logic [$clog2(N_SYN)-1:0]   mem_addr,
   input  logic signed [W_WIDTH-1:0]  mem_rdata,
   output logic signed [W_WIDTH-1:0]  mem_wdata,
   output logic [HIST_LEN-1:0]        enc_pre,
   output logic [HIST_LEN-1:0]        enc_post,
   output logic signed [W_WIDTH-1:0]  enc_cur_w,
   input  logic signed [W_WIDTH-1:0]  enc_new_w,
   output logic                       busy,
   output logic                       done,
   output logic                       overrun
);

   localparam int                IDX_W    = $clog2(N_SYN);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_SYN - 1);

   sched_state_t      state, state_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   weight_t           cur_w;
   weight_t           wdata_fmt;
   hist_t             pre_word, post_word;
   logic              accept;

   stdp_spike_history #(
      .N_SYN (N_SYN),
      .IDX_W (IDX_W)
   ) u_hist (
      .clk        (clk),
      .rst        (rst),
      .shift      (accept),
      .pre_spike  (pre_spike),
      .post_spike (post_spike),
      .sel        (idx),
      .pre_word   (pre_word),
      .post_word  (post_word)
   );

`ifdef STDP_CLAMP_EN
   assign wdata_fmt = sat_weight(enc_new_w, weight_t'(W_MIN), weight_t'(W_MAX));
`else
   assign wdata_fmt = enc_new_w;
`endif

   // Kept outside the FSM block: enc_new_w is combinational from enc_cur_w
   // through the external encoder, so the FSM must not depend on it.
   assign enc_cur_w = (!rst && state == W2) ? cur_w : '0;
   assign mem_wdata = mem_we ? wdata_fmt : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         cur_w <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (state == W1) begin
            cur_w <= mem_rdata;
         end
      end
   end

   // All outputs are forced low while rst is high so a W2 caught by reset
   // never issues its write.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      accept    = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      enc_pre   = '0;
      enc_post  = '0;
      busy      = 1'b0;
      done      = 1'b0;
      overrun   = 1'b0;
      if (!rst) begin
         busy    = (state != IDLE);
         overrun = tick && (state != IDLE);
         case (state)
            IDLE: begin
               if (tick) begin
                  accept    = 1'b1;
                  idx_nxt   = '0;
                  state_nxt = RD;
               end
            end
            RD: begin
               // Histories already hold the post-shift value here.
               mem_re    = 1'b1;
               mem_addr  = idx;
               enc_pre   = pre_word;
               enc_post  = post_word;
               state_nxt = W1;
            end
            W1: begin
               state_nxt = W2;
            end
            W2: begin
               // Only synapses with a spike this step (either side) change.
               if (pre_word[HIST_LEN-1] | post_word[HIST_LEN-1]) begin
                  mem_we   = 1'b1;
                  mem_addr = idx;
               end
               if (idx == LAST_IDX) begin
                  state_nxt = DONE;
               end else begin
                  idx_nxt   = idx + 1'b1;
                  state_nxt = RD;
               end
            end
            DONE: begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stdp_sweep_scheduler.sv
// Purpose : self-checking bench for stdp_sweep_scheduler with a weight RAM, a 2-stage
//           encoder and a step-level reference model of the weight updates.
// Latency : n/a.
// Backpr. : n/a.
module tb_stdp_sweep_scheduler;

   localparam int N          = 8;
   localparam int SWEEP_DONE = 3 * N + 1;

   logic                clk = 1'b0;
   logic                rst, tick, post_spike;
   logic [N-1:0]        pre_spike;
   logic                mem_re, mem_we, busy, done, overrun;
   logic [2:0]          mem_addr;
   logic signed [19:0]  mem_rdata, mem_wdata, enc_cur_w, enc_new_w;
   logic [15:0]         enc_pre, enc_post;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stdp_sweep_scheduler #(.N_SYN(N), .W_MIN(0), .W_MAX(1023)) dut (
      .clk(clk), .rst(rst), .tick(tick), .pre_spike(pre_spike), .post_spike(post_spike),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .mem_wdata(mem_wdata), .enc_pre(enc_pre), .enc_post(enc_post), .enc_cur_w(enc_cur_w),
      .enc_new_w(enc_new_w), .busy(busy), .done(done), .overrun(overrun)
   );

   // STDP rule: latest spike positions in each history; TD = t_pre - t_post.
   // |TD| <= 9 gives 100 - 10*|TD| with the sign of TD; a missing spike gives 0.
   function automatic int stdp_delta(input logic [15:0] pre, input logic [15:0] post);
      int tp, tq, td, mag;
      tp = -1;
      tq = -1;
      for (int b = 0; b < 16; b++) begin
         if (pre[b])  tp = b;
         if (post[b]) tq = b;
      end
      if (tp < 0 || tq < 0) return 0;
      td  = tp - tq;
      mag = 100 - 10 * (td < 0 ? -td : td);
      if (mag < 0) mag = 0;
      if (td > 0) return mag;
      if (td < 0) return -mag;
      return 0;
   endfunction

   // Weight RAM: read data one cycle after mem_re; bench preload port.
   logic signed [19:0] wram [N];
   logic               ld_en = 1'b0;
   logic [2:0]         ld_addr = '0;
   logic signed [19:0] ld_val = '0;
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= wram[mem_addr];
      if (mem_we) wram[mem_addr] <= mem_wdata;
      if (ld_en)  wram[ld_addr] <= ld_val;
   end

   // Encoder: stage 1 captures the words, stage 2 holds the delta, sum is combinational.
   logic [15:0]        e1_pre = '0, e1_post = '0;
   logic signed [19:0] e2_delta = '0;
   always @(posedge clk) begin
      e1_pre   <= enc_pre;
      e1_post  <= enc_post;
      e2_delta <= 20'(stdp_delta(e1_pre, e1_post));
   end
   assign enc_new_w = enc_cur_w + e2_delta;

   // Reference model at time-step granularity.
   logic [15:0] m_pre [N];
   logic [15:0] m_post;
   int          m_w [N];
   logic [22:0] exp_q[$];
   logic [22:0] obs_q[$];

   function automatic int wrap20(input int v);
      logic signed [19:0] t;
      t = v[19:0];
      return int'(t);
   endfunction

   function automatic void model_tick(input logic [N-1:0] pre, input logic post);
      int nv;
      exp_q.delete();
      for (int i = 0; i < N; i++) m_pre[i] = {pre[i], m_pre[i][15:1]};
      m_post = {post, m_post[15:1]};
      for (int i = 0; i < N; i++) begin
         if (m_pre[i][15] || m_post[15]) begin
            nv = wrap20(m_w[i] + stdp_delta(m_pre[i], m_post));
`ifdef STDP_CLAMP_EN
            if (nv < 0)    nv = 0;
            if (nv > 1023) nv = 1023;
`endif
            m_w[i] = nv;
            exp_q.push_back({3'(i), 20'(nv)});
         end
      end
   endfunction

   // Sweep observations.
   int          done_at, overlap, n_ovr, busy_gap;
   logic        idle_busy;
   logic [15:0] obs_epre [N];
   logic [15:0] obs_epost;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int i, input int v);
      ld_en = 1'b1; ld_addr = 3'(i); ld_val = 20'(v);
      step();
      ld_en = 1'b0;
      m_w[i] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1; tick = 1'b0; pre_spike = '0; post_spike = 1'b0;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < N; i++) m_pre[i] = '0;
      m_post = '0;
   endtask

   // Drives one accepted tick at cycle 0, optional dropped ticks at cycles ovr_a/ovr_b,
   // records every write, and returns in the first idle cycle after done.
   task automatic do_sweep(input logic [N-1:0] pre, input logic post, input int ovr_a, input int ovr_b);
      obs_q.delete();
      done_at = -1; overlap = 0; n_ovr = 0; busy_gap = 0;
      for (int i = 0; i < N; i++) obs_epre[i] = 16'hxxxx;
      obs_epost = 16'hxxxx;
      model_tick(pre, post);
      tick = 1'b1; pre_spike = pre; post_spike = post;
      step();
      for (int c = 1; c <= 4 * N + 10; c++) begin
         tick = (c == ovr_a || c == ovr_b);
         pre_spike  = tick ? N'($urandom) : '0;
         post_spike = tick ? 1'($urandom) : 1'b0;
         #1;
         if (mem_re && mem_we) overlap++;
         if (!busy) busy_gap++;
         if (overrun) n_ovr++;
         if (mem_we) obs_q.push_back({mem_addr, mem_wdata});
         if (mem_re) begin
            obs_epre[mem_addr] = enc_pre;
            obs_epost = enc_post;
         end
         if (done && done_at < 0) done_at = c;
         step();
         if (done_at >= 0) break;
      end
      tick = 1'b0; pre_spike = '0; post_spike = 1'b0;
      #1;
      idle_busy = busy;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({mem_re, mem_we, mem_addr, mem_wdata, enc_pre, enc_post, enc_cur_w, busy, done, overrun} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got re=%b we=%b addr=%0d busy=%b done=%b ovr=%b expected all zero",
                  mem_re, mem_we, mem_addr, busy, done, overrun);
      end
   endtask

   task automatic test_single_pre();
      do_reset();
      load(0, 500);
      do_sweep(8'h01, 1'b0, -1, -1);
      checks++;
      if (done_at != SWEEP_DONE) begin errors++; $display("FAIL pre1_done_cycle: got %0d expected %0d", done_at, SWEEP_DONE); end
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== {3'd0, 20'sd500}) begin
         errors++; $display("FAIL pre1_write: got %0d writes first %h expected 1 write %h", obs_q.size(), obs_q[0], {3'd0, 20'sd500});
      end
      checks++;
      if (obs_epre[0] !== 16'h8000) begin errors++; $display("FAIL pre1_enc_pre: got %h expected 8000", obs_epre[0]); end
      checks++;
      if (overlap != 0 || busy_gap != 0 || idle_busy !== 1'b0) begin
         errors++; $display("FAIL pre1_busy_re_we: got overlap=%0d gaps=%0d idle_busy=%b expected 0 0 0", overlap, busy_gap, idle_busy);
      end
   endtask

   task automatic test_post_after_pre();
      do_sweep(8'h00, 1'b1, -1, -1);
      checks++;
      if (obs_q.size() != N || obs_q[0] !== {3'd0, 20'sd410}) begin
         errors++; $display("FAIL post1_write0: got %0d writes first %h expected %0d writes first %h", obs_q.size(), obs_q[0], N, {3'd0, 20'sd410});
      end
      checks++;
      if (obs_epre[0] !== 16'h4000 || obs_epost !== 16'h8000) begin
         errors++; $display("FAIL post1_enc_words: got pre=%h post=%h expected 4000 8000", obs_epre[0], obs_epost);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL post1_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      else foreach (exp_q[k]) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL post1_write[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_pre_after_post();
      do_reset();
      load(2, 100);
      do_sweep(8'h00, 1'b1, -1, -1);
      do_sweep(8'h04, 1'b0, -1, -1);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== {3'd2, 20'sd190}) begin
         errors++; $display("FAIL ltp_write: got %0d writes first %h expected 1 write %h", obs_q.size(), obs_q[0], {3'd2, 20'sd190});
      end
      checks++;
      if (obs_epost !== 16'h4000) begin errors++; $display("FAIL ltp_post_hist: got %h expected 4000", obs_epost); end
   endtask

   task automatic test_overrun();
      do_reset();
      do_sweep(8'h81, 1'b1, -1, -1);
      do_sweep(N'($urandom), 1'b1, 5, SWEEP_DONE);
      checks++;
      if (n_ovr != 2) begin errors++; $display("FAIL ovr_pulses: got %0d expected 2", n_ovr); end
      checks++;
      if (done_at != SWEEP_DONE) begin errors++; $display("FAIL ovr_done_cycle: got %0d expected %0d", done_at, SWEEP_DONE); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      else foreach (exp_q[k]) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL ovr_write[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]); end
      end
      // Following sweep shows whether the dropped ticks disturbed the histories.
      do_sweep(N'($urandom), 1'b1, -1, -1);
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovr_after_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      else foreach (exp_q[k]) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL ovr_after_write[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_reset_mid_sweep();
      logic signed [19:0] w0;
      do_reset();
      do_sweep(8'hFF, 1'b1, -1, -1);
      w0 = wram[0];
      tick = 1'b1; pre_spike = 8'hFF; post_spike = 1'b1;
      step();
      tick = 1'b0; pre_spike = '0; post_spike = 1'b0;
      step();
      step();
      #1;
      checks++;
      if (mem_we !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got mem_we=%b expected 1", mem_we); end
      rst = 1'b1;
      #1;
      checks++;
      if ({mem_we, mem_re, busy, done} !== 4'b0) begin
         errors++; $display("FAIL rstmid_outputs: got we=%b re=%b busy=%b done=%b expected 0", mem_we, mem_re, busy, done);
      end
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      checks++;
      if (wram[0] !== w0) begin errors++; $display("FAIL rstmid_no_write: got %0d expected %0d", wram[0], w0); end
      for (int i = 0; i < N; i++) m_pre[i] = '0;
      m_post = '0;
      do_sweep(8'h00, 1'b0, -1, -1);
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_writes: got %0d expected 0", obs_q.size()); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (obs_epre[i] !== 16'h0 || obs_epost !== 16'h0) begin
            errors++; $display("FAIL rstmid_hist[%0d]: got pre=%h post=%h expected 0 0", i, obs_epre[i], obs_epost);
         end
      end
   endtask

   task automatic test_clamp();
      logic signed [19:0] exp_lo, exp_hi;
`ifdef STDP_CLAMP_EN
      exp_lo = 20'sd0;
      exp_hi = 20'sd1023;
`else
      exp_lo = -20'sd50;
      exp_hi = 20'sd1090;
`endif
      do_reset();
      load(0, 1000);
      load(1, 40);
      do_sweep(8'h02, 1'b0, -1, -1);
      do_sweep(8'h00, 1'b1, -1, -1);
      checks++;
      if (obs_q.size() != N || obs_q[1] !== {3'd1, exp_lo}) begin
         errors++; $display("FAIL clamp_low: got %0d writes entry1 %h expected %h", obs_q.size(), obs_q[1], {3'd1, exp_lo});
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL clamp_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      else foreach (exp_q[k]) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL clamp_write[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]); end
      end
      do_sweep(8'h01, 1'b0, -1, -1);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== {3'd0, exp_hi}) begin
         errors++; $display("FAIL clamp_high: got %0d writes first %h expected %h", obs_q.size(), obs_q[0], {3'd0, exp_hi});
      end
   endtask

   task automatic test_wrap();
      logic signed [19:0] exp_w;
`ifdef STDP_CLAMP_EN
      exp_w = 20'sd1023;
`else
      exp_w = -20'sd524206;
`endif
      do_reset();
      load(3, 524280);
      do_sweep(8'h00, 1'b1, -1, -1);
      do_sweep(8'h08, 1'b0, -1, -1);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== {3'd3, exp_w}) begin
         errors++; $display("FAIL wrap_write: got %0d writes first %h expected %h", obs_q.size(), obs_q[0], {3'd3, exp_w});
      end
   endtask

   task automatic test_random();
      int oa;
      do_reset();
      for (int i = 0; i < N; i++) load(i, int'($urandom_range(0, 4000)) - 2000);
      for (int it = 0; it < 30; it++) begin
         oa = (it % 4 == 0) ? int'($urandom_range(1, SWEEP_DONE)) : -1;
         do_sweep(N'($urandom), 1'($urandom), oa, -1);
         checks++;
         if (done_at != SWEEP_DONE || overlap != 0) begin
            errors++; $display("FAIL rand_timing[%0d]: got done=%0d overlap=%0d expected %0d 0", it, done_at, overlap, SWEEP_DONE);
         end
         checks++;
         if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", it, obs_q.size(), exp_q.size()); end
         else foreach (exp_q[k]) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_write[%0d.%0d]: got %h expected %h", it, k, obs_q[k], exp_q[k]); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; pre_spike = '0; post_spike = 1'b0;
      for (int i = 0; i < N; i++) m_w[i] = 0;
      test_reset();
      for (int i = 0; i < N; i++) load(i, int'($urandom_range(0, 4000)) - 2000);
      test_single_pre();
      test_post_after_pre();
      test_pre_after_post();
      test_overrun();
      test_reset_mid_sweep();
      test_clamp();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
